// File: rtl/hazard_interlock_pkg.sv
// hazard_interlock_pkg: shared definitions for the ID/EXE interlock.
//   - halt_state_t : halt sequencing FSM states
//   - FWD_*        : operand forward-select codes
//   - fwd_sel()    : priority encode of per-stage hits (EXE > MEM > WB)
package hazard_interlock_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // hits[0]=EXE, hits[1]=MEM, hits[2]=WB; youngest writer wins
  function automatic logic [1:0] fwd_sel(input logic [2:0] hits);
    if (hits[0])      return FWD_EXE;
    else if (hits[1]) return FWD_MEM;
    else if (hits[2]) return FWD_WB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_interlock_reg_match.sv
// reg_match: one source-vs-writer compare.
//   src     : source register number in ID
//   use_src : ID instruction is valid and really reads src
//   wr      : writer stage writes a register
//   dest    : writer stage destination
//   hit     : dependency on this writer (r0 never matches)
module reg_match (
  input  logic       use_src,
  input  logic [4:0] src,
  input  logic       wr,
  input  logic [4:0] dest,
  output logic       hit
);
  assign hit = use_src & wr & (dest == src) & (src != 5'd0);
endmodule

// File: rtl/hazard_interlock.sv
// hazard_interlock: ID-stage interlock, forwarding select, halt drain and
// stall-cycle counter.
//   clock, reset           : clock, synchronous active-high reset
//   I_*                    : instruction in ID (valid, sources, uses, halt)
//   E_* / M_* / W_*        : register writers in EXE / MEM / WB
//   stall                  : freeze PC, IF/ID, ID/EXE
//   bubble                 : clear ID/EXE on this edge
//   FwdA, FwdB             : operand selects (only with HAZARD_FORWARD_EN)
//   halted                 : pipeline drained after a halt
//   stall_count            : saturating count of stall cycles
// Macro HAZARD_FORWARD_EN: enables forwarding (load-use-only stalls and the
// FwdA/FwdB ports). Undefined: stall on any in-flight writer dependency.
module hazard_interlock
  import hazard_interlock_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             I_Valid,
  input  logic [4:0]       I_RS,
  input  logic [4:0]       I_RT,
  input  logic             I_UseRS,
  input  logic             I_UseRT,
  input  logic             I_Halt,
  input  logic             E_WriteReg,
  input  logic             E_ReadMem,
  input  logic [4:0]       E_REG,
  input  logic             M_WriteReg,
  input  logic [4:0]       M_REG,
  input  logic             W_WriteReg,
  input  logic [4:0]       W_REG,
  output logic             stall,
  output logic             bubble,
`ifdef HAZARD_FORWARD_EN
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
`endif
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // source 0 = RS, 1 = RT; stage 0 = EXE, 1 = MEM, 2 = WB
  logic [1:0][4:0] src;
  logic [1:0]      use_v;
  logic [2:0]      wr;
  logic [2:0][4:0] dst;
  logic [1:0][2:0] hit;

  assign src   = {I_RT, I_RS};
  assign use_v = {I_Valid & I_UseRT, I_Valid & I_UseRS};
  assign wr    = {W_WriteReg, M_WriteReg, E_WriteReg};
  assign dst   = {W_REG, M_REG, E_REG};

  for (genvar s = 0; s < 2; s++) begin : g_src
    for (genvar x = 0; x < 3; x++) begin : g_stg
      reg_match u_match (
        .use_src (use_v[s]),
        .src     (src[s]),
        .wr      (wr[x]),
        .dest    (dst[x]),
        .hit     (hit[s][x])
      );
    end
  end

  logic hz;
`ifdef HAZARD_FORWARD_EN
  // only a load in EXE cannot be forwarded in time
  assign hz   = E_ReadMem & (hit[0][0] | hit[1][0]);
  assign FwdA = reset ? FWD_RF : fwd_sel(hit[0]);
  assign FwdB = reset ? FWD_RF : fwd_sel(hit[1]);
`else
  // register file is not write-through, so WB writers stall too
  assign hz = |hit;
  logic unused_rdmem;
  assign unused_rdmem = E_ReadMem;
`endif

  halt_state_t   state;
  logic [DW-1:0] drain_cnt;

  assign stall  = ~reset & ((state != ST_RUN) | hz);
  assign bubble = reset | stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      drain_cnt   <= '0;
      stall_count <= '0;
      halted      <= 1'b0;
    end else begin
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
      case (state)
        ST_RUN: begin
          // a coincident hazard holds the halt in ID until it clears
          if (I_Valid & I_Halt & ~hz) begin
            state     <= ST_DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_interlock.sv
// tb_hazard_interlock: directed and random stimulus against a behavioural
// model of the interlock rules (youngest-writer lookup, halt edge counting).
// Works for both builds; HAZARD_FORWARD_EN selects the model variant.
module tb_hazard_interlock;

  localparam int DC = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 0, reset;
  logic I_Valid, I_UseRS, I_UseRT, I_Halt;
  logic [4:0] I_RS, I_RT, E_REG, M_REG, W_REG;
  logic E_WriteReg, E_ReadMem, M_WriteReg, W_WriteReg;
  logic stall, bubble, halted;
  logic [CW-1:0] stall_count;
  logic [1:0] FwdA, FwdB;

  int total = 0, bad = 0;
  int since = -1;   // edges since halt entered ID/EXE, -1 = no halt
  int cnt = 0;
  bit mv = 0;       // model state is known (after first reset edge)

  always #5 clock = ~clock;

  hazard_interlock #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .I_Valid(I_Valid), .I_RS(I_RS), .I_RT(I_RT),
    .I_UseRS(I_UseRS), .I_UseRT(I_UseRT), .I_Halt(I_Halt),
    .E_WriteReg(E_WriteReg), .E_ReadMem(E_ReadMem), .E_REG(E_REG),
    .M_WriteReg(M_WriteReg), .M_REG(M_REG),
    .W_WriteReg(W_WriteReg), .W_REG(W_REG),
    .stall(stall), .bubble(bubble),
`ifdef HAZARD_FORWARD_EN
    .FwdA(FwdA), .FwdB(FwdB),
`endif
    .halted(halted), .stall_count(stall_count)
  );

`ifndef HAZARD_FORWARD_EN
  assign FwdA = 2'd0;
  assign FwdB = 2'd0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // youngest in-flight writer of source s: 1 EXE, 2 MEM, 3 WB, 0 none
  function automatic int writer(input logic [4:0] s, input logic u);
    if (!I_Valid || !u || s == 0) return 0;
    if (E_WriteReg && E_REG == s) return 1;
    if (M_WriteReg && M_REG == s) return 2;
    if (W_WriteReg && W_REG == s) return 3;
    return 0;
  endfunction

  function automatic bit model_hz();
    int wa = writer(I_RS, I_UseRS);
    int wb = writer(I_RT, I_UseRT);
`ifdef HAZARD_FORWARD_EN
    return E_ReadMem && (wa == 1 || wb == 1);
`else
    return wa != 0 || wb != 0;
`endif
  endfunction

  function automatic bit model_stall();
    return !reset && (since >= 0 || model_hz());
  endfunction

  task automatic idle();
    I_Valid = 0; I_RS = 0; I_RT = 0; I_UseRS = 0; I_UseRT = 0; I_Halt = 0;
    E_WriteReg = 0; E_ReadMem = 0; E_REG = 0;
    M_WriteReg = 0; M_REG = 0; W_WriteReg = 0; W_REG = 0;
    reset = 0;
  endtask

  // check combinational outputs, clock once, advance model, check registers
  task automatic step();
    bit st;
    #2;
    st = model_stall();
    check("stall", stall, st);
    check("bubble", bubble, reset || st);
`ifdef HAZARD_FORWARD_EN
    check("fwdA", FwdA, reset ? 0 : writer(I_RS, I_UseRS));
    check("fwdB", FwdB, reset ? 0 : writer(I_RT, I_UseRT));
`endif
    @(posedge clock);
    if (reset) begin
      since = -1; cnt = 0; mv = 1;
    end else begin
      if (st && cnt < CMAX) cnt++;
      if (since >= 0) begin
        if (since < 1000) since++;
      end else if (I_Valid && I_Halt && !model_hz()) since = 0;
    end
    #1;
    if (mv) begin
      check("halted", halted, since >= DC);
      check("stall_count", stall_count, cnt);
    end
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    idle();

    // dependency on EXE writer r3 moving EXE -> MEM -> WB
    I_Valid = 1; I_RS = 3; I_UseRS = 1;
    E_WriteReg = 1; E_REG = 3; step();
    E_WriteReg = 0; M_WriteReg = 1; M_REG = 3; step();
    M_WriteReg = 0; W_WriteReg = 1; W_REG = 3; step();
    W_WriteReg = 0; step();
`ifdef HAZARD_FORWARD_EN
    check("dep_cnt", stall_count, 0);
`else
    check("dep_cnt", stall_count, 3);
`endif

    // load-use r5, then writer in MEM
    idle(); reset = 1; step(); idle();
    I_Valid = 1; I_RS = 5; I_UseRS = 1;
    E_WriteReg = 1; E_ReadMem = 1; E_REG = 5; step();
    E_WriteReg = 0; E_ReadMem = 0; M_WriteReg = 1; M_REG = 5; step();

    // ALU dependency on RT r7, also matched by WB
    idle(); I_Valid = 1; I_RT = 7; I_UseRT = 1;
    E_WriteReg = 1; E_REG = 7; step();
    W_WriteReg = 1; W_REG = 7; step();

    // r0 and unused source
    idle(); I_Valid = 1; I_UseRS = 1; E_WriteReg = 1; step();
    I_UseRS = 0; I_RS = 9; E_REG = 9; step();

    // halt coincident with load-use, accepted next cycle, then drain
    idle(); reset = 1; step(); idle();
    I_Valid = 1; I_Halt = 1; I_RS = 4; I_UseRS = 1;
    E_WriteReg = 1; E_ReadMem = 1; E_REG = 4; step();
    E_WriteReg = 0; E_ReadMem = 0; step();
    idle();
    for (int i = 0; i < DC + 2; i++) step();
    check("halted_late", halted, 1);

    // reset during drain
    idle(); reset = 1; step(); idle();
    I_Valid = 1; I_Halt = 1; step();
    idle(); step();
    reset = 1; step();
    check("rst_halted", halted, 0);
    check("rst_cnt", stall_count, 0);
    idle(); step();

    // random traffic with occasional halts and resets
    for (int n = 0; n < 1500; n++) begin
      I_Valid    = $urandom_range(0, 3) != 0;
      I_RS       = 5'($urandom_range(0, 3));
      I_RT       = 5'($urandom_range(0, 3));
      I_UseRS    = $urandom_range(0, 1);
      I_UseRT    = $urandom_range(0, 1);
      I_Halt     = $urandom_range(0, 40) == 0;
      E_WriteReg = $urandom_range(0, 1);
      E_ReadMem  = $urandom_range(0, 1);
      E_REG      = 5'($urandom_range(0, 3));
      M_WriteReg = $urandom_range(0, 1);
      M_REG      = 5'($urandom_range(0, 3));
      W_WriteReg = $urandom_range(0, 1);
      W_REG      = 5'($urandom_range(0, 3));
      reset      = $urandom_range(0, 30) == 0;
      step();
    end

    // counter saturation while halted
    idle(); reset = 1; step(); idle();
    I_Valid = 1; I_Halt = 1; step();
    idle();
    for (int i = 0; i < CMAX + 5; i++) step();
    check("cnt_sat", stall_count, CMAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
